// File: rtl/ttw_mem_arb.sv
// Round-robin arbiter sharing one table-walk memory port among N walkers, with per-walker
// outstanding limits. Optional perf counters under `TTW_MEM_ARB_PERF_EN.
module ttw_mem_arb #(
    parameter int N       = 4,
    parameter int IDX_W   = 2,
    parameter int MCN_W   = 64,
    parameter int MAX_OUT = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         ttw_req_i_valid,
    output logic [N-1:0]         ttw_req_i_ready,
    input  logic [N*MCN_W-1:0]   ttw_req_i_bits_mcn,
    output logic [N-1:0]         ttw_res_o_valid,
    output logic [511:0]         ttw_res_o_bits_data,
    output logic                 mem_req_o_valid,
    input  logic                 mem_req_o_ready,
    output logic [IDX_W-1:0]     mem_req_o_bits_idx,
    output logic [MCN_W-1:0]     mem_req_o_bits_mcn,
    input  logic                 mem_res_i_valid,
    output logic                 mem_res_i_ready,
    input  logic [IDX_W-1:0]     mem_res_i_bits_idx,
    input  logic [511:0]         mem_res_i_bits_data,
    output logic                 err_o
`ifdef TTW_MEM_ARB_PERF_EN
    ,
    output logic [N*32-1:0]      perf_grant_o,
    output logic [31:0]          perf_stall_o
`endif
);

    localparam int CNT_W = 3;

    logic [N-1:0][CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0]        r_rr;
    logic                    r_slice_vld;
    logic [IDX_W-1:0]        r_slice_idx;
    logic [MCN_W-1:0]        r_slice_mcn;
    logic                    r_res_rdy;
    logic [N-1:0]            r_res_vld;
    logic [511:0]            r_res_data;
    logic                    r_err;

    logic [N-1:0]            w_elig;
    logic [N-1:0]            w_inc;
    logic [N-1:0]            w_dec;
    logic [N-1:0]            w_res_hit;
    logic [N-1:0]            w_cnt_nz;
    logic                    w_load;
    logic                    w_gnt_any;
    logic                    w_gnt;
    logic [IDX_W-1:0]        w_gnt_idx;
    logic [MCN_W-1:0]        w_gnt_mcn;
    logic                    w_res_acc;
    logic                    w_res_ok;
    logic                    w_res_bad;

    assign w_load = !r_slice_vld || mem_req_o_ready;

    // Search starts at the rr pointer and wraps, so the last-granted walker goes to the back.
    always_comb begin
        int j;
        j         = 0;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_gnt_mcn = '0;
        for (int w = 0; w < N; w++) begin
            w_elig[w]    = ttw_req_i_valid[w] && (r_cnt[w] < CNT_W'(MAX_OUT));
            w_cnt_nz[w]  = (r_cnt[w] != '0);
            w_res_hit[w] = (mem_res_i_bits_idx == IDX_W'(w));
        end
        for (int k = 0; k < N; k++) begin
            j = int'(r_rr) + k;
            if (j >= N) j = j - N;
            if (!w_gnt_any && w_elig[j]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = IDX_W'(j);
                w_gnt_mcn = ttw_req_i_bits_mcn[j*MCN_W +: MCN_W];
            end
        end
    end

    assign w_gnt     = w_gnt_any && w_load && !reset;
    assign w_res_acc = mem_res_i_valid && r_res_rdy;
    assign w_res_ok  = w_res_acc && |(w_res_hit & w_cnt_nz);
    assign w_res_bad = w_res_acc && !w_res_ok;

    always_comb begin
        for (int w = 0; w < N; w++) begin
            w_inc[w] = w_gnt && (w_gnt_idx == IDX_W'(w));
            w_dec[w] = w_res_ok && w_res_hit[w];
        end
    end

    assign ttw_req_i_ready = w_inc;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt       <= '0;
            r_rr        <= '0;
            r_slice_vld <= 1'b0;
            r_slice_idx <= '0;
            r_slice_mcn <= '0;
            r_res_rdy   <= 1'b0;
            r_res_vld   <= '0;
            r_res_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_res_rdy <= 1'b1;
            if (w_load) begin
                r_slice_vld <= w_gnt;
                if (w_gnt) begin
                    r_slice_idx <= w_gnt_idx;
                    r_slice_mcn <= w_gnt_mcn;
                end
            end
            if (w_gnt) begin
                r_rr <= (w_gnt_idx == IDX_W'(N-1)) ? '0 : w_gnt_idx + 1'b1;
            end
            for (int w = 0; w < N; w++) begin
                case ({w_inc[w], w_dec[w]})
                    2'b10:   r_cnt[w] <= r_cnt[w] + CNT_W'(1);
                    2'b01:   r_cnt[w] <= r_cnt[w] - CNT_W'(1);
                    default: r_cnt[w] <= r_cnt[w];
                endcase
            end
            r_res_vld <= w_res_ok ? w_res_hit : '0;
            if (w_res_ok) r_res_data <= mem_res_i_bits_data;
            if (w_res_bad) r_err <= 1'b1;
        end
    end

    assign mem_req_o_valid     = r_slice_vld;
    assign mem_req_o_bits_idx  = r_slice_idx;
    assign mem_req_o_bits_mcn  = r_slice_mcn;
    assign mem_res_i_ready     = r_res_rdy;
    assign ttw_res_o_valid     = r_res_vld;
    assign ttw_res_o_bits_data = r_res_data;
    assign err_o               = r_err;

`ifdef TTW_MEM_ARB_PERF_EN
    logic [N-1:0][31:0] r_perf_gnt;
    logic [31:0]        r_perf_stall;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_perf_gnt   <= '0;
            r_perf_stall <= '0;
        end else begin
            for (int w = 0; w < N; w++) begin
                if (w_inc[w]) r_perf_gnt[w] <= r_perf_gnt[w] + 32'd1;
            end
            if (r_slice_vld && !mem_req_o_ready) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_grant_o = r_perf_gnt;
    assign perf_stall_o = r_perf_stall;
`endif

endmodule
